register_file_multiport_v2: RTL and testbench
=============================================

Name: register_file_multiport_v2

Overview:
- Parametrised physical register file for the out-of-order core: a data array plus a per-entry state field, with WRITE_PORTS write ports and READ_PORTS read ports.
- Data and state write enables are independent per port, and same-address write conflicts resolve deterministically.
- Read latency is selectable (0 or 1); the optional bypass feature provides write-to-read forwarding.
- Sits between rename/issue (state reads) and execute/writeback (data writes).

Parameters:
- DATA_WIDTH, 64, width of each data entry
- PHYS_COUNT, 128, number of physical entries
- ADDR_WIDTH, $clog2(PHYS_COUNT), entry address width; derived, not overridden
- WRITE_PORTS, 4, number of write ports
- READ_PORTS, 8, number of read ports
- STATE_WIDTH, 4, width of the per-entry state field
- RESET_STATE, 0, value loaded into every state entry on reset
- READ_LATENCY, 1, 0 = combinational read, 1 = registered read
- ZERO_REG, 1, 1 = entry 0 is hardwired (data 0, state RESET_STATE, writes ignored)

Ports:
- clk  in  1  clock
- async_rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable
- wr_addr  in  WRITE_PORTS x ADDR_WIDTH  write address per port
- wr_data  in  WRITE_PORTS x DATA_WIDTH  write data per port
- wr_data_en  in  WRITE_PORTS  data write enable per port
- wr_state  in  WRITE_PORTS x STATE_WIDTH  state write value per port
- wr_state_en  in  WRITE_PORTS  state write enable per port
- rd_addr  in  READ_PORTS x ADDR_WIDTH  read address per port
- rd_data_en  in  READ_PORTS  data read enable per port
- rd_state_en  in  READ_PORTS  state read enable per port
- rd_data  out  READ_PORTS x DATA_WIDTH  read data per port
- rd_state  out  READ_PORTS x STATE_WIDTH  read state per port
- wr_conflict  out  1  registered pulse: two or more enabled ports wrote the same address in the previous cycle

Behaviour:
- Reset (asynchronous assertion, released synchronously to clk):
  - all data entries = 0; all state entries = RESET_STATE
  - rd_data = 0, rd_state = RESET_STATE, wr_conflict = 0
- Reset mid-operation aborts any pending write; no partial update is allowed.
- Writes commit on posedge clk when clk_en = 1:
  - Data and state are written independently; a port may write both fields in one cycle.
  - Address >= PHYS_COUNT: the write is ignored.
  - ZERO_REG = 1 and address 0: the write is ignored.
- Write conflict, same field and same address on several ports: the highest-numbered port wins.
  - Conflicts are checked per field: port 0 writing data and port 1 writing state to the same address both take effect.
- wr_conflict:
  - Asserts for one cycle, the cycle after a conflicting data or state write.
  - Forced to 0 while clk_en = 0.
  - A ZERO_REG address-0 conflict does not flag.
- Reads are evaluated independently per port:
  - Data read enabled: rd_data = array value. Not enabled: rd_data = 0 (READ_LATENCY 0) or holds its previous value (READ_LATENCY 1).
  - State read follows the same rule using rd_state_en and rd_state.
  - Out-of-range or ZERO_REG address 0: data 0, state RESET_STATE.
- READ_LATENCY 1:
  - Output registers capture at posedge when clk_en = 1; they hold when clk_en = 0.
  - Latency is 1 cycle from address to output.
- Read and write to the same address in the same cycle, without bypass: the read returns the pre-write value.
- clk_en = 0: array and outputs frozen; combinational reads (READ_LATENCY 0) remain live.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - A read matching an enabled write address in the same cycle returns the incoming wr_data / wr_state, with highest-numbered-port priority.
  - The forwarded value is combinational for READ_LATENCY 0 and registered for READ_LATENCY 1.
  - Forwarding is gated by clk_en and ZERO_REG.
- Undefined: no forwarding; same-cycle reads return the old value.

Test Plan:
- Reset values:
  - Stimulus: assert async_rst_n low mid-cycle with writes pending; deassert; read addresses 5 and 127.
  - Required: rd_data = 0, rd_state = RESET_STATE, wr_conflict = 0.
  - Required: reset takes effect without waiting for a clk edge.
- Basic write/read:
  - Stimulus: port 2 writes data 0xDEAD_BEEF and state 0x3 to address 17; next cycle read port 6 reads address 17 (READ_LATENCY 1).
  - Required: rd_data[6] = 0xDEAD_BEEF and rd_state[6] = 0x3 one cycle later.
- Write conflict:
  - Stimulus: ports 0 and 3 write data 0x11 and 0x33 to address 9 in the same cycle.
  - Required: address 9 holds 0x33; wr_conflict = 1 for exactly one cycle.
  - Stimulus: port 0 writes data and port 1 writes state 0x5 to address 9.
  - Required: both updates land; wr_conflict stays 0.
- Zero register:
  - Stimulus: ZERO_REG = 1; write 0xFF to address 0; read address 0.
  - Required: rd_data = 0.
  - Stimulus: two ports write address 0.
  - Required: wr_conflict = 0.
- Same-cycle read/write on address 40 (old value 0x1, write 0x2):
  - REGFILE_BYPASS_EN defined: read returns 0x2.
  - REGFILE_BYPASS_EN undefined: read returns 0x1; the following read returns 0x2.
- clk_en and enables:
  - Stimulus: hold clk_en = 0 while asserting writes to address 3.
  - Required: address 3 is unchanged and registered outputs hold.
  - Stimulus: drop rd_data_en with READ_LATENCY 1.
  - Required: rd_data keeps its last value.

Source files
------------

// File: rtl/register_file_multiport_v2.sv
// Multi-port physical register file: data array plus per-entry state, WRITE_PORTS writers, READ_PORTS readers.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module register_file_multiport_v2 #(
  parameter int DATA_WIDTH   = 64,
  parameter int PHYS_COUNT   = 128,
  parameter int ADDR_WIDTH   = $clog2(PHYS_COUNT),
  parameter int WRITE_PORTS  = 4,
  parameter int READ_PORTS   = 8,
  parameter int STATE_WIDTH  = 4,
  parameter int RESET_STATE  = 0,
  parameter int READ_LATENCY = 1,
  parameter int ZERO_REG     = 1
) (
  input  logic                                    clk,
  input  logic                                    async_rst_n,
  input  logic                                    clk_en,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  wr_addr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [WRITE_PORTS-1:0]                  wr_data_en,
  input  logic [WRITE_PORTS-1:0][STATE_WIDTH-1:0] wr_state,
  input  logic [WRITE_PORTS-1:0]                  wr_state_en,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   rd_addr,
  input  logic [READ_PORTS-1:0]                   rd_data_en,
  input  logic [READ_PORTS-1:0]                   rd_state_en,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   rd_data,
  output logic [READ_PORTS-1:0][STATE_WIDTH-1:0]  rd_state,
  output logic                                    wr_conflict
);

  localparam logic [STATE_WIDTH-1:0] LP_RESET_STATE = STATE_WIDTH'(RESET_STATE);

  logic [1:0]                                  r_rst_sync;
  logic                                        w_rst_n;
  logic [DATA_WIDTH-1:0]                       r_data  [PHYS_COUNT];
  logic [STATE_WIDTH-1:0]                      r_state [PHYS_COUNT];
  logic                                        r_wr_conflict;
  logic                                        w_conflict;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]       w_rd_data;
  logic [READ_PORTS-1:0][STATE_WIDTH-1:0]      w_rd_state;

  // An address is usable when it is in range and not the hardwired zero entry.
  function automatic logic f_addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < PHYS_COUNT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) r_rst_sync <= '0;
    else              r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      // NOTE: every entry must read as zero/RESET_STATE after reset, so the array itself is reset, not just the outputs.
      for (int i = 0; i < PHYS_COUNT; i++) begin
        r_data[i]  <= '0;
        r_state[i] <= LP_RESET_STATE;
      end
    end else if (clk_en) begin
      // NOTE: non-blocking updates in ascending port order make the last (highest-numbered) port win a same-address race.
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_data_en[p] && f_addr_ok(wr_addr[p]))
          r_data[wr_addr[p]] <= wr_data[p];
        if (wr_state_en[p] && f_addr_ok(wr_addr[p]))
          r_state[wr_addr[p]] <= wr_state[p];
      end
    end
  end

  // Conflicts are per field; ignored writes (zero entry, out of range) never flag.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned and infers a latch.
    w_conflict = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      for (int q = p + 1; q < WRITE_PORTS; q++) begin
        if (wr_addr[p] == wr_addr[q] && f_addr_ok(wr_addr[p])) begin
          if (wr_data_en[p] && wr_data_en[q])   w_conflict = 1'b1;
          if (wr_state_en[p] && wr_state_en[q]) w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_wr_conflict <= 1'b0;
    else          r_wr_conflict <= clk_en && w_conflict;
  end
  assign wr_conflict = r_wr_conflict;

  always_comb begin
    w_rd_data  = '0;
    w_rd_state = {READ_PORTS{LP_RESET_STATE}};
    for (int r = 0; r < READ_PORTS; r++) begin
      if (f_addr_ok(rd_addr[r])) begin
        w_rd_data[r]  = r_data[rd_addr[r]];
        w_rd_state[r] = r_state[rd_addr[r]];
      end
`ifdef REGFILE_BYPASS_EN
      if (clk_en) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (wr_addr[p] == rd_addr[r] && f_addr_ok(wr_addr[p])) begin
            if (wr_data_en[p])  w_rd_data[r]  = wr_data[p];
            if (wr_state_en[p]) w_rd_state[r] = wr_state[p];
          end
        end
      end
`else
      // Without forwarding a same-cycle read sees the pre-write array contents.
`endif
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_rd_comb
      always_comb begin
        rd_data  = '0;
        rd_state = {READ_PORTS{LP_RESET_STATE}};
        for (int r = 0; r < READ_PORTS; r++) begin
          if (rd_data_en[r])  rd_data[r]  = w_rd_data[r];
          if (rd_state_en[r]) rd_state[r] = w_rd_state[r];
        end
      end
    end else begin : g_rd_reg
      logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  r_rd_data;
      logic [READ_PORTS-1:0][STATE_WIDTH-1:0] r_rd_state;

      // Disabled ports hold their last captured value.
      always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          r_rd_data  <= '0;
          r_rd_state <= {READ_PORTS{LP_RESET_STATE}};
        end else if (clk_en) begin
          for (int r = 0; r < READ_PORTS; r++) begin
            if (rd_data_en[r])  r_rd_data[r]  <= w_rd_data[r];
            if (rd_state_en[r]) r_rd_state[r] <= w_rd_state[r];
          end
        end
      end
      assign rd_data  = r_rd_data;
      assign rd_state = r_rd_state;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_multiport_v2.sv
// Directed bench for register_file_multiport_v2 at default parameters (READ_LATENCY 1, ZERO_REG 1).
module tb_register_file_multiport_v2;

  localparam int DW = 64;
  localparam int AW = 7;
  localparam int WP = 4;
  localparam int RP = 8;
  localparam int SW = 4;

  logic                   clk;
  logic                   async_rst_n;
  logic                   clk_en;
  logic [WP-1:0][AW-1:0]  wr_addr;
  logic [WP-1:0][DW-1:0]  wr_data;
  logic [WP-1:0]          wr_data_en;
  logic [WP-1:0][SW-1:0]  wr_state;
  logic [WP-1:0]          wr_state_en;
  logic [RP-1:0][AW-1:0]  rd_addr;
  logic [RP-1:0]          rd_data_en;
  logic [RP-1:0]          rd_state_en;
  logic [RP-1:0][DW-1:0]  rd_data;
  logic [RP-1:0][SW-1:0]  rd_state;
  logic                   wr_conflict;

  int total = 0;
  int bad   = 0;

  register_file_multiport_v2 dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_data_en  (wr_data_en),
    .wr_state    (wr_state),
    .wr_state_en (wr_state_en),
    .rd_addr     (rd_addr),
    .rd_data_en  (rd_data_en),
    .rd_state_en (rd_state_en),
    .rd_data     (rd_data),
    .rd_state    (rd_state),
    .wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wr_addr     = '0;
    wr_data     = '0;
    wr_data_en  = '0;
    wr_state    = '0;
    wr_state_en = '0;
  endtask

  task automatic clear_reads();
    rd_addr     = '0;
    rd_data_en  = '0;
    rd_state_en = '0;
  endtask

  task automatic test_reset();
    clear_writes();
    clear_reads();
    wr_addr[0] = 7'd5; wr_data[0] = 64'h55; wr_state[0] = 4'h7;
    wr_data_en[0] = 1'b1; wr_state_en[0] = 1'b1;
    rd_addr[0] = 7'd5; rd_data_en[0] = 1'b1; rd_state_en[0] = 1'b1;
    tick();
    clear_writes();
    tick();
    total++;
    if (rd_data[0] !== 64'h55) begin
      $display("FAIL reset_pre_data: got %h want %h", rd_data[0], 64'h55); bad++;
    end
    wr_addr[1] = 7'd127; wr_data[1] = 64'h77; wr_data_en[1] = 1'b1;
    #2 async_rst_n = 1'b0;
    #1;
    total++;
    if (rd_data[0] !== 64'h0 || rd_state[0] !== 4'h0 || wr_conflict !== 1'b0) begin
      $display("FAIL reset_async: data=%h state=%h conf=%b want 0/0/0", rd_data[0], rd_state[0], wr_conflict); bad++;
    end
    tick();
    clear_writes();
    tick();
    async_rst_n = 1'b1;
    repeat (3) tick();
    rd_addr[0] = 7'd5;   rd_data_en[0] = 1'b1; rd_state_en[0] = 1'b1;
    rd_addr[1] = 7'd127; rd_data_en[1] = 1'b1; rd_state_en[1] = 1'b1;
    tick();
    total++;
    if (rd_data[0] !== 64'h0 || rd_state[0] !== 4'h0) begin
      $display("FAIL reset_addr5: data=%h state=%h want 0/0", rd_data[0], rd_state[0]); bad++;
    end
    total++;
    if (rd_data[1] !== 64'h0 || rd_state[1] !== 4'h0 || wr_conflict !== 1'b0) begin
      $display("FAIL reset_addr127: data=%h state=%h conf=%b want 0/0/0", rd_data[1], rd_state[1], wr_conflict); bad++;
    end
    clear_reads();
  endtask

  task automatic test_basic();
    clear_writes();
    wr_addr[2] = 7'd17; wr_data[2] = 64'hDEAD_BEEF; wr_state[2] = 4'h3;
    wr_data_en[2] = 1'b1; wr_state_en[2] = 1'b1;
    tick();
    clear_writes();
    rd_addr[6] = 7'd17; rd_data_en[6] = 1'b1; rd_state_en[6] = 1'b1;
    tick();
    total++;
    if (rd_data[6] !== 64'hDEAD_BEEF) begin
      $display("FAIL basic_data: got %h want %h", rd_data[6], 64'hDEAD_BEEF); bad++;
    end
    total++;
    if (rd_state[6] !== 4'h3) begin
      $display("FAIL basic_state: got %h want 3", rd_state[6]); bad++;
    end
    clear_reads();
  endtask

  task automatic test_conflict();
    clear_writes();
    wr_addr[0] = 7'd9; wr_data[0] = 64'h11; wr_data_en[0] = 1'b1;
    wr_addr[3] = 7'd9; wr_data[3] = 64'h33; wr_data_en[3] = 1'b1;
    tick();
    total++;
    if (wr_conflict !== 1'b1) begin
      $display("FAIL conflict_pulse: got %b want 1", wr_conflict); bad++;
    end
    clear_writes();
    rd_addr[0] = 7'd9; rd_data_en[0] = 1'b1; rd_state_en[0] = 1'b1;
    tick();
    total++;
    if (wr_conflict !== 1'b0 || rd_data[0] !== 64'h33) begin
      $display("FAIL conflict_winner: conf=%b data=%h want 0/%h", wr_conflict, rd_data[0], 64'h33); bad++;
    end
    // Different fields on the same address: both land, no flag.
    wr_addr[0] = 7'd9; wr_data[0] = 64'h44; wr_data_en[0] = 1'b1;
    wr_addr[1] = 7'd9; wr_state[1] = 4'h5; wr_state_en[1] = 1'b1;
    tick();
    total++;
    if (wr_conflict !== 1'b0) begin
      $display("FAIL conflict_split_flag: got %b want 0", wr_conflict); bad++;
    end
    clear_writes();
    tick();
    total++;
    if (rd_data[0] !== 64'h44 || rd_state[0] !== 4'h5) begin
      $display("FAIL conflict_split_data: data=%h state=%h want 44/5", rd_data[0], rd_state[0]); bad++;
    end
    wr_addr[1] = 7'd10; wr_state[1] = 4'h1; wr_state_en[1] = 1'b1;
    wr_addr[2] = 7'd10; wr_state[2] = 4'h2; wr_state_en[2] = 1'b1;
    rd_addr[0] = 7'd10;
    tick();
    total++;
    if (wr_conflict !== 1'b1) begin
      $display("FAIL conflict_state_flag: got %b want 1", wr_conflict); bad++;
    end
    clear_writes();
    tick();
    total++;
    if (rd_state[0] !== 4'h2 || wr_conflict !== 1'b0) begin
      $display("FAIL conflict_state_winner: state=%h conf=%b want 2/0", rd_state[0], wr_conflict); bad++;
    end
    clear_reads();
  endtask

  task automatic test_zero_reg();
    clear_writes();
    wr_addr[0] = 7'd0; wr_data[0] = 64'hFF; wr_state[0] = 4'hF;
    wr_data_en[0] = 1'b1; wr_state_en[0] = 1'b1;
    tick();
    clear_writes();
    rd_addr[3] = 7'd0; rd_data_en[3] = 1'b1; rd_state_en[3] = 1'b1;
    tick();
    total++;
    if (rd_data[3] !== 64'h0 || rd_state[3] !== 4'h0) begin
      $display("FAIL zero_reg_read: data=%h state=%h want 0/0", rd_data[3], rd_state[3]); bad++;
    end
    wr_addr[1] = 7'd0; wr_data[1] = 64'hA1; wr_data_en[1] = 1'b1;
    wr_addr[2] = 7'd0; wr_data[2] = 64'hA2; wr_data_en[2] = 1'b1;
    tick();
    total++;
    if (wr_conflict !== 1'b0) begin
      $display("FAIL zero_reg_conflict: got %b want 0", wr_conflict); bad++;
    end
    clear_writes();
    clear_reads();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] exp_first;
`ifdef REGFILE_BYPASS_EN
    exp_first = 64'h2;
`else
    exp_first = 64'h1;
`endif
    clear_writes();
    wr_addr[0] = 7'd40; wr_data[0] = 64'h1; wr_data_en[0] = 1'b1;
    tick();
    wr_data[0] = 64'h2;
    rd_addr[4] = 7'd40; rd_data_en[4] = 1'b1;
    tick();
    total++;
    if (rd_data[4] !== exp_first) begin
      $display("FAIL same_cycle_read: got %h want %h", rd_data[4], exp_first); bad++;
    end
    clear_writes();
    tick();
    total++;
    if (rd_data[4] !== 64'h2) begin
      $display("FAIL same_cycle_next: got %h want 2", rd_data[4]); bad++;
    end
    clear_reads();
  endtask

  task automatic test_clk_en();
    clear_writes();
    wr_addr[0] = 7'd3; wr_data[0] = 64'h30; wr_data_en[0] = 1'b1;
    tick();
    clear_writes();
    rd_addr[5] = 7'd3; rd_data_en[5] = 1'b1; rd_state_en[5] = 1'b1;
    tick();
    total++;
    if (rd_data[5] !== 64'h30) begin
      $display("FAIL clk_en_pre: got %h want %h", rd_data[5], 64'h30); bad++;
    end
    clk_en = 1'b0;
    wr_addr[0] = 7'd3; wr_data[0] = 64'h99; wr_data_en[0] = 1'b1;
    wr_addr[1] = 7'd3; wr_data[1] = 64'h98; wr_data_en[1] = 1'b1;
    rd_addr[5] = 7'd17;
    repeat (2) tick();
    total++;
    if (rd_data[5] !== 64'h30 || rd_state[5] !== 4'h0) begin
      $display("FAIL clk_en_hold: data=%h state=%h want 30/0", rd_data[5], rd_state[5]); bad++;
    end
    total++;
    if (wr_conflict !== 1'b0) begin
      $display("FAIL clk_en_conflict: got %b want 0", wr_conflict); bad++;
    end
    clk_en = 1'b1;
    clear_writes();
    rd_addr[5] = 7'd3;
    tick();
    total++;
    if (rd_data[5] !== 64'h30) begin
      $display("FAIL clk_en_array: got %h want %h", rd_data[5], 64'h30); bad++;
    end
    // Data read disabled holds; state read on the same port still follows address 17.
    rd_addr[5] = 7'd17; rd_data_en[5] = 1'b0; rd_state_en[5] = 1'b1;
    tick();
    total++;
    if (rd_data[5] !== 64'h30 || rd_state[5] !== 4'h3) begin
      $display("FAIL rd_en_hold: data=%h state=%h want 30/3", rd_data[5], rd_state[5]); bad++;
    end
    clear_reads();
  endtask

  initial begin
    async_rst_n = 1'b0;
    clk_en      = 1'b1;
    clear_writes();
    clear_reads();
    repeat (2) tick();
    async_rst_n = 1'b1;
    repeat (3) tick();
    test_reset();
    test_basic();
    test_conflict();
    test_zero_reg();
    test_same_cycle();
    test_clk_en();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
